// File: rtl/winograd_pre_transform_ctrl.sv
// winograd_pre_transform_ctrl
//   Computes the F(4x4,3x3) Winograd input-tile transform V = B^T * d * B on a
//   stream of 6x6 tiles. The work is done by one shared 6-point B^T product
//   (the 1D unit). A column pass builds T = B^T * d, and a row pass produces
//   V = T * B one row at a time.
//
//   Ports:
//     clk, rst       rising-edge clock; synchronous active-high reset
//     start          pulse that begins a job of num_tiles tiles (ignored while busy)
//     num_tiles      number of tiles in the job, sampled when start is accepted
//     busy, done     busy while a job runs; done pulses for 1 cycle as busy drops
//     in_valid/in_ready/in_row    input row stream, element k at [32k+31:32k]
//     out_valid/out_ready/out_row output row stream (row i of V), element j at [32j+31:32j]
//     out_row_idx    row index i (0..5) of out_row
//     out_last_row   high when out_row_idx == 5 (qualify with out_valid)
//     out_tile_idx   0-based index of the tile being output
//     dbg_state      current FSM state, for observation only
//
//   Handshake: a row moves on a rising edge where valid and ready are both high.
//   The producer holds valid and the data stable until that edge. Here, ready
//   and valid are decoded purely from the FSM state, so neither one depends
//   combinationally on the other side.
module winograd_pre_transform_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CNT_W-1:0]    num_tiles,
  output logic                busy,
  output logic                done,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [6*DATA_W-1:0] in_row,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [6*DATA_W-1:0] out_row,
  output logic [2:0]          out_row_idx,
  output logic                out_last_row,
  output logic [CNT_W-1:0]    out_tile_idx,
  output logic [1:0]          dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_COL  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [1:0]        state;
  logic [2:0]        row_cnt;
  logic [2:0]        col_cnt;
  logic [CNT_W-1:0]  num_q;
  logic [DATA_W-1:0] d_mem [6][6];
  logic [DATA_W-1:0] t_mem [6][6];
  logic [DATA_W-1:0] u_in  [6];
  logic [DATA_W-1:0] u_out [6];

  assign busy         = (state != S_IDLE);
  assign in_ready     = (state == S_LOAD);
  assign out_valid    = (state == S_OUT);
  assign out_last_row = (out_row_idx == 3'd5);
  assign dbg_state    = state;

  // The shared unit reads column j of D during the column pass. At all other
  // times it reads row i of T. T only changes during the column pass, so
  // out_row stays stable while the output is stalled.
  always_comb begin
    for (int k = 0; k < 6; k++) begin
      if (state == S_COL) u_in[k] = d_mem[k][col_cnt];
      else                u_in[k] = t_mem[out_row_idx][k];
    end
  end

  // 6-point B^T product. Shift-and-add form; all arithmetic wraps mod 2^DATA_W.
  always_comb begin
    u_out[0] = (u_in[0] << 2) - (u_in[2] << 2) - u_in[2] + u_in[4];
    u_out[1] = u_in[3] + u_in[4] - (u_in[1] << 2) - (u_in[2] << 2);
    u_out[2] = (u_in[1] << 2) - (u_in[2] << 2) - u_in[3] + u_in[4];
    u_out[3] = (u_in[3] << 1) - (u_in[1] << 1) - u_in[2] + u_in[4];
    u_out[4] = (u_in[1] << 1) - (u_in[3] << 1) - u_in[2] + u_in[4];
    u_out[5] = (u_in[1] << 2) - (u_in[3] << 2) - u_in[3] + u_in[5];
  end

  always_comb begin
    out_row = '0;
    for (int j = 0; j < 6; j++) out_row[DATA_W*j +: DATA_W] = u_out[j];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      done         <= 1'b0;
      row_cnt      <= '0;
      col_cnt      <= '0;
      num_q        <= '0;
      out_row_idx  <= '0;
      out_tile_idx <= '0;
      for (int r = 0; r < 6; r++) begin
        for (int c = 0; c < 6; c++) begin
          d_mem[r][c] <= '0;
          t_mem[r][c] <= '0;
        end
      end
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (num_tiles != '0) begin
              num_q        <= num_tiles;
              row_cnt      <= '0;
              col_cnt      <= '0;
              out_row_idx  <= '0;
              out_tile_idx <= '0;
              state        <= S_LOAD;
            end else begin
              // An empty job completes at once without touching the datapath.
              done <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            for (int k = 0; k < 6; k++) d_mem[row_cnt][k] <= in_row[DATA_W*k +: DATA_W];
            if (row_cnt == 3'd5) begin
              col_cnt <= '0;
              state   <= S_COL;
            end else begin
              row_cnt <= row_cnt + 3'd1;
            end
          end
        end
        S_COL: begin
          for (int k = 0; k < 6; k++) t_mem[k][col_cnt] <= u_out[k];
          if (col_cnt == 3'd5) begin
            out_row_idx <= '0;
            state       <= S_OUT;
          end else begin
            col_cnt <= col_cnt + 3'd1;
          end
        end
        default: begin // S_OUT
          if (out_ready) begin
            if (out_row_idx == 3'd5) begin
              out_row_idx <= '0;
              row_cnt     <= '0;
              if ((out_tile_idx + CNT_W'(1)) == num_q) begin
                done  <= 1'b1;
                state <= S_IDLE;
              end else begin
                out_tile_idx <= out_tile_idx + CNT_W'(1);
                state        <= S_LOAD;
              end
            end else begin
              out_row_idx <= out_row_idx + 3'd1;
            end
          end
        end
      endcase
    end
  end

endmodule
